// File: rtl/mcc_pipe_adder.sv
// mcc_pipe_adder: pipelined Manchester-carry-chain adder/subtractor.
// W-bit operands are split into NSEG = W/SEG segments; each pipeline stage
// resolves one SEG-bit carry chain and registers its carry for the next stage.
// Operands and completed sum bits ride along with each beat so the whole
// result lines up in the final stage. A valid/ready handshake stalls the
// entire pipeline together when the output is blocked.
// Optional feature: define MCC_PIPE_SATURATE_EN to add the 'sat' input,
// which clamps signed-overflowing results in the final stage.
module mcc_pipe_adder #(
    parameter int W   = 16,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
`ifdef MCC_PIPE_SATURATE_EN
    input  logic         sat,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int NSEG = W / SEG;

    // Per-stage registers: index k holds the beat after segment k was resolved.
    logic         v_q [NSEG];
    logic [W-1:0] a_q [NSEG];
    logic [W-1:0] b_q [NSEG];
    logic [W-1:0] s_q [NSEG];
    logic         c_q [NSEG];
    logic         ovf_q;

    // Stage inputs (what each stage sees from its upstream neighbour).
    logic         in_v_s [NSEG];
    logic [W-1:0] in_a_s [NSEG];
    logic [W-1:0] in_b_s [NSEG];
    logic [W-1:0] in_s_s [NSEG];
    logic         in_c_s [NSEG];

    // Stage next-state values.
    logic [W-1:0] s_d [NSEG];
    logic         c_d [NSEG];
    logic         ovf_d;

`ifdef MCC_PIPE_SATURATE_EN
    logic         sat_q    [NSEG];
    logic         in_sat_s [NSEG];
`endif

    logic en_s;

    // The whole pipeline advances only when the output slot can be refilled.
    assign en_s      = out_ready | ~v_q[NSEG-1];
    assign in_ready  = en_s;
    assign out_valid = v_q[NSEG-1];
    assign sum       = s_q[NSEG-1];
    assign cout      = c_q[NSEG-1];
    assign ovf       = ovf_q;

    // Route each stage's inputs: stage 0 from the ports (with subtract prep),
    // later stages from the previous stage's registers.
    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            in_v_s[k] = in_valid;
            in_a_s[k] = a;
            in_b_s[k] = sub ? ~b : b;
            in_s_s[k] = {W{1'b0}};
            in_c_s[k] = sub ? 1'b1 : cin;
`ifdef MCC_PIPE_SATURATE_EN
            in_sat_s[k] = sat;
`endif
        end
        for (int k = 1; k < NSEG; k++) begin
            in_v_s[k] = v_q[k-1];
            in_a_s[k] = a_q[k-1];
            in_b_s[k] = b_q[k-1];
            in_s_s[k] = s_q[k-1];
            in_c_s[k] = c_q[k-1];
`ifdef MCC_PIPE_SATURATE_EN
            in_sat_s[k] = sat_q[k-1];
`endif
        end
    end

    // Resolve one SEG-bit carry chain per stage; track the carry into the MSB
    // for signed overflow and apply the optional clamp at the last stage.
    always_comb begin
        logic [W-1:0] s_v;
        logic         c_v;
        logic         g_v;
        logic         p_v;
        logic         cmsb_v;
        int           idx;
        s_v    = {W{1'b0}};
        c_v    = 1'b0;
        g_v    = 1'b0;
        p_v    = 1'b0;
        cmsb_v = 1'b0;
        idx    = 0;
        for (int k = 0; k < NSEG; k++) begin
            s_v = in_s_s[k];
            c_v = in_c_s[k];
            for (int j = 0; j < SEG; j++) begin
                idx = k * SEG + j;
                g_v = in_a_s[k][idx] & in_b_s[k][idx];
                p_v = in_a_s[k][idx] ^ in_b_s[k][idx];
                if (idx == W - 1) begin
                    cmsb_v = c_v;
                end else begin
                    cmsb_v = cmsb_v;
                end
                s_v[idx] = p_v ^ c_v;
                c_v      = g_v | (p_v & c_v);
            end
            s_d[k] = s_v;
            c_d[k] = c_v;
        end
        ovf_d = cmsb_v ^ c_d[NSEG-1];
`ifdef MCC_PIPE_SATURATE_EN
        if (in_sat_s[NSEG-1] && ovf_d) begin
            if (!in_a_s[NSEG-1][W-1] && !in_b_s[NSEG-1][W-1]) begin
                s_d[NSEG-1] = {1'b0, {(W-1){1'b1}}};
            end else if (in_a_s[NSEG-1][W-1] && in_b_s[NSEG-1][W-1]) begin
                s_d[NSEG-1] = {1'b1, {(W-1){1'b0}}};
            end else begin
                s_d[NSEG-1] = s_d[NSEG-1];
            end
        end else begin
            s_d[NSEG-1] = s_d[NSEG-1];
        end
`endif
    end

    // Pipeline registers: cleared asynchronously, advanced together on en;
    // bubbles move the valid bit only and leave data registers untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= {W{1'b0}};
                b_q[k] <= {W{1'b0}};
                s_q[k] <= {W{1'b0}};
                c_q[k] <= 1'b0;
`ifdef MCC_PIPE_SATURATE_EN
                sat_q[k] <= 1'b0;
`endif
            end
            ovf_q <= 1'b0;
        end else if (en_s) begin
            for (int k = 0; k < NSEG; k++) begin
                v_q[k] <= in_v_s[k];
                if (in_v_s[k]) begin
                    a_q[k] <= in_a_s[k];
                    b_q[k] <= in_b_s[k];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
`ifdef MCC_PIPE_SATURATE_EN
                    sat_q[k] <= in_sat_s[k];
`endif
                end
            end
            if (in_v_s[NSEG-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_mcc_pipe_adder.sv
// Self-checking bench for mcc_pipe_adder: directed test-plan vectors,
// backpressure stream, asynchronous reset mid-flight and a random stream,
// all scored against an arithmetic reference model through a queue.
module tb_mcc_pipe_adder;

    localparam int W    = 16;
    localparam int SEG  = 4;
    localparam int NSEG = W / SEG;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         lat;
        logic [31:0]  cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
`ifdef MCC_PIPE_SATURATE_EN
    logic         sat;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic acc;

    always #5 clk = ~clk;

    mcc_pipe_adder #(.W(W), .SEG(SEG)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
`ifdef MCC_PIPE_SATURATE_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on W+1 bits, signed overflow from sign rules.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input logic sb, input logic st);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         sat_on;
        exp_t         r;
`ifdef MCC_PIPE_SATURATE_EN
        sat_on = 1'b1;
`else
        sat_on = 1'b0;
`endif
        be     = sb ? ~bv : bv;
        full   = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
        r      = '0;
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (av[W-1] == be[W-1]) && (full[W-1] != av[W-1]);
        if (st && r.ovf && sat_on)
            r.sum = av[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return r;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o, input logic l);
        exp_t r;
        r = '0; r.sum = s; r.cout = c; r.ovf = o; r.lat = l;
        return r;
    endfunction

    // One cycle: drive at negedge, sample #1 later, score transfers and acceptances.
    task automatic step(input logic iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb, input logic ordy,
                        input exp_t e, output logic accepted);
        exp_t f;
        @(negedge clk);
        cyc++;
        in_valid = iv; a = av; b = bv; cin = ci; sub = sb; out_ready = ordy;
        #1;
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else if (out_ready) begin
                f = q.pop_front();
                chk("sum", {16'd0, sum}, {16'd0, f.sum});
                chk("cout", {31'd0, cout}, {31'd0, f.cout});
                chk("ovf", {31'd0, ovf}, {31'd0, f.ovf});
                if (f.lat) chk("latency", cyc - f.cyc, NSEG);
            end else begin
                chk("hold_sum", {16'd0, sum}, {16'd0, q[0].sum});
            end
        end
        accepted = iv && in_ready;
        if (accepted) begin
            f = e;
            f.cyc = cyc;
            q.push_back(f);
        end
    endtask

    task automatic idle(input logic ordy);
        logic dummy;
        step(1'b0, '0, '0, 1'b0, 1'b0, ordy, '0, dummy);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() > 0; i++) idle(1'b1);
        chk("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
`ifdef MCC_PIPE_SATURATE_EN
        sat = 1'b0;
`endif
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Directed test-plan vectors, with latency checking.
        step(1'b1, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, mk(16'h2233, 1'b0, 1'b0, 1'b1), acc);
        drain();
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1), acc);
        step(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, mk(16'h0001, 1'b1, 1'b0, 1'b1), acc);
        step(1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b1), acc);
        step(1'b1, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b0, 1'b1), acc);
        drain();

`ifdef MCC_PIPE_SATURATE_EN
        sat = 1'b1;
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h7FFF, 1'b0, 1'b1, 1'b1), acc);
        sat = 1'b0;
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, mk(16'h8000, 1'b0, 1'b1, 1'b1), acc);
        sat = 1'b1;
        step(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, mk(16'h8000, 1'b1, 1'b1, 1'b1), acc);
        sat = 1'b0;
        drain();
`endif

        // Eight back-to-back beats with a 3-cycle output stall mid-stream.
        begin
            int   sent;
            int   t;
            logic ordy;
            logic [W-1:0] av;
            logic [W-1:0] bv;
            sent = 0;
            t = 0;
            while (sent < 8 && t < 40) begin
                ordy = !(t >= 5 && t <= 7);
                av = W'(sent);
                bv = W'(16'h0100 * sent);
                step(1'b1, av, bv, 1'b0, 1'b0, ordy, model(av, bv, 1'b0, 1'b0, 1'b0), acc);
                chk("stall_in_ready", {31'd0, in_ready}, {31'd0, ordy});
                if (!ordy) chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                if (acc) sent++;
                t++;
            end
            chk("stream_sent", sent, 32'd8);
            drain();
        end

        // Asynchronous reset between edges with beats in flight.
        step(1'b1, 16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0, model(16'h0101, 16'h0202, 1'b0, 1'b0, 1'b0), acc);
        step(1'b1, 16'h0303, 16'h0404, 1'b0, 1'b0, 1'b0, model(16'h0303, 16'h0404, 1'b0, 1'b0, 1'b0), acc);
        step(1'b1, 16'h0505, 16'h0606, 1'b0, 1'b0, 1'b0, model(16'h0505, 16'h0606, 1'b0, 1'b0, 1'b0), acc);
        idle(1'b0);
        idle(1'b0);
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_sum", {16'd0, sum}, 32'd0);
        chk("arst_cout", {31'd0, cout}, 32'd0);
        chk("arst_ovf", {31'd0, ovf}, 32'd0);
        q.delete();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < NSEG; i++) begin
            idle(1'b1);
            chk("post_rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, mk(16'h3333, 1'b0, 1'b0, 1'b1), acc);
        drain();

        // Random stream with random bubbles and backpressure.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] av;
            logic [W-1:0] bv;
            logic ci;
            logic sb;
            logic st;
            logic iv;
            logic ordy;
            av   = W'($urandom);
            bv   = W'($urandom);
            ci   = 1'($urandom);
            sb   = 1'($urandom);
            st   = 1'($urandom);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 7);
            if ((i % 16) == 0) begin
                av = {1'b0, {(W-1){1'b1}}};
                bv = W'(1);
            end
`ifdef MCC_PIPE_SATURATE_EN
            sat = st;
`endif
            step(iv, av, bv, ci, sb, ordy, model(av, bv, ci, sb, st), acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mcc_pipe_adder.md
Name: mcc_pipe_adder

Overview:
- Pipelined, parametrised successor to the combinational Manchester carry chain adder.
- Supports the vedic multiplier partial-product accumulation and the adaptive-filter tap update path.
- Operand width is split into SEG-bit carry-chain segments with one register stage per segment, so clock rate is set by one SEG-bit chain rather than the full width.
- Adds carry-in, add/subtract mode, signed overflow and a valid/ready stream handshake with backpressure.

Parameters:
- W, 16, operand and result width in bits; must be a multiple of SEG.
- SEG, 4, bits per carry-chain segment; must be at least 1.
- NSEG, W/SEG, derived localparam; pipeline depth. Not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: A+B+cin. 1: A−B, computed as A+~B+1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  W  result.
- cout  out  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset: rst is asynchronous and active-high.
  - Immediately clears every stage valid bit and every data register.
  - out_valid=0, sum=0, cout=0, ovf=0 while rst is high and after release.
  - Beats in flight when rst asserts are discarded; none emerge after release.
- Handshake:
  - Global enable en = out_ready | ~out_valid.
  - in_ready = en. This is a combinational path from out_ready; it is intentional and documented.
  - A beat is accepted when in_valid & in_ready.
  - A result transfers when out_valid & out_ready.
  - When en=0, all stages hold their state, including bubbles.
- Operand prep at acceptance:
  - b_eff = sub ? ~b : b.
  - c_in = sub ? 1 : cin.
- Stage k (k = 0..NSEG−1) computes segment bits [k*SEG +: SEG]:
  - Per bit: G = a & b_eff, P = a ^ b_eff, c[i+1] = G | (P & c[i]), s = P ^ c[i].
  - The segment carry-in comes from the stage k−1 registered carry; stage 0 uses c_in.
- Skew registers:
  - Operand bits for segments not yet processed travel with the beat.
  - Completed sum segments are carried forward, so all W result bits align at the final stage.
- Latency and throughput:
  - Exactly NSEG cycles from acceptance to out_valid when there is no stall. For W=16, SEG=4 this is 4.
  - One beat per cycle sustained.
  - Order is preserved; no beat is dropped or duplicated under any out_ready pattern.
- Outputs are registered. sum, cout and ovf are stable while out_valid=1 and out_ready=0.
- Flags:
  - cout = carry out of bit W−1.
  - ovf = carry into bit W−1 XOR carry out of bit W−1. This holds for both add and sub modes.
- Edge cases:
  - When W==SEG (NSEG=1) the block is a single registered stage with latency 1.
  - Simultaneous accept and emit in the same cycle is normal streaming.
  - A bubble (in_valid=0) propagates as valid=0 and does not update the output registers.

Optional Feature:
- Macro: MCC_PIPE_SATURATE_EN.
- When defined:
  - Adds input port sat (1 bit), captured with each beat and piped alongside it.
  - If sat=1 and ovf=1, sum is clamped: to 2^(W−1)−1 when the operands' effective sign bits are both 0, and to −2^(W−1) when both are 1.
  - ovf and cout still report the unsaturated condition.
  - Latency is unchanged; the clamp happens in the final stage.
- When undefined: no sat port, and sum always carries the wrapped result.

Test Plan:
- W=16, SEG=4, sub=0, cin=0: a=0x1234, b=0x0FFF → sum=0x2233, cout=0, ovf=0; out_valid rises exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. With cin=1 → sum=0x0001, cout=1.
- sub=1: a=0x7FFF, b=0xFFFF → sum=0x8000, cout=0, ovf=1. Also a=0x0005, b=0x0003 → sum=0x0002, cout=1, ovf=0.
- Stream of 8 back-to-back beats (a=i, b=0x0100*i) with out_ready held low for 3 cycles mid-stream:
  - in_ready is low for the same 3 cycles.
  - All 8 results arrive in order and are correct.
  - The output is held stable during the stall.
- Assert rst asynchronously, between clock edges, with 3 beats in flight:
  - out_valid drops immediately.
  - No result appears in the NSEG cycles after release.
  - A new beat accepted after release completes normally.
- With MCC_PIPE_SATURATE_EN defined:
  - a=0x7FFF, b=0x0001, sat=1 → sum=0x7FFF, ovf=1.
  - Same beat with sat=0 → sum=0x8000.
  - a=0x8000, b=0xFFFF, sat=1 → sum=0x8000.
